// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the icache/dcache miss arbiter.
// Line and thread widths follow the core configuration.
package mem_arbiter_pkg;

  localparam int THR_PER_CORE_WIDTH      = 2;
  localparam int ICACHE_LINE_WIDTH       = 64;
  localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
  } memory_request_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mem_arb_state_t;

  typedef enum logic {
    SRC_IC,
    SRC_DC
  } mem_arb_src_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter funnelling icache/dcache misses
// to main memory, one transaction in flight, with timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,

  input  logic                          ic_req_valid,
  input  memory_request_t               ic_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] ic_req_thread_id,
  output logic                          ic_req_grant,
  output logic                          ic_rsp_valid,
  output logic [ICACHE_LINE_WIDTH-1:0]  ic_rsp_data,
  output logic [THR_PER_CORE_WIDTH-1:0] ic_rsp_thread_id,
  output logic                          ic_rsp_bus_error,

  input  logic                          dc_req_valid,
  input  memory_request_t               dc_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] dc_req_thread_id,
  output logic                          dc_req_grant,
  output logic                          dc_rsp_valid,
  output logic [ICACHE_LINE_WIDTH-1:0]  dc_rsp_data,
  output logic [THR_PER_CORE_WIDTH-1:0] dc_rsp_thread_id,
  output logic                          dc_rsp_bus_error,

  output logic                          mm_req_valid,
  output memory_request_t               mm_req_info,
  input  logic                          mm_req_ready,
  input  logic                          mm_rsp_valid,
  input  logic [ICACHE_LINE_WIDTH-1:0]  mm_rsp_data,
  input  logic                          mm_rsp_bus_error,

  output logic                          stray_rsp
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_arb_state_t                r_state;
  mem_arb_state_t                w_state_nxt;
  mem_arb_src_t                  r_src;
  mem_arb_src_t                  r_rr_last;
  memory_request_t               r_info;
  logic [THR_PER_CORE_WIDTH-1:0] r_thr;
  logic [ICACHE_LINE_WIDTH-1:0]  r_data;
  logic                          r_berr;
  logic                          r_stray;
  logic [7:0]                    r_cnt;

  logic w_gnt_ic;
  logic w_gnt_dc;
  logic w_gnt;
  logic w_resp;

  // Ties go to whichever side was not granted last.
  always_comb begin
    w_gnt_ic = 1'b0;
    w_gnt_dc = 1'b0;
    if (r_state == IDLE && !reset) begin
      unique case ({ic_req_valid, dc_req_valid})
        2'b10:   w_gnt_ic = 1'b1;
        2'b01:   w_gnt_dc = 1'b1;
        2'b11: begin
          if (r_rr_last == SRC_DC) w_gnt_ic = 1'b1;
          else                     w_gnt_dc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_gnt = w_gnt_ic | w_gnt_dc;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt) w_state_nxt = ISSUE;
      ISSUE:   if (mm_req_ready) w_state_nxt = WAIT;
      WAIT: begin
        if (mm_rsp_valid || r_cnt == TO_LAST)
          w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_src     <= SRC_IC;
      r_rr_last <= SRC_DC;
      r_info    <= '0;
      r_thr     <= '0;
      r_data    <= '0;
      r_berr    <= 1'b0;
      r_stray   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_src     <= w_gnt_ic ? SRC_IC : SRC_DC;
        r_rr_last <= w_gnt_ic ? SRC_IC : SRC_DC;
        r_info    <= w_gnt_ic ? ic_req_info : dc_req_info;
        r_thr     <= w_gnt_ic ? ic_req_thread_id
                              : dc_req_thread_id;
      end
      if (r_state == ISSUE && mm_req_ready)
        r_cnt <= '0;
      // A response in the final cycle beats the timeout.
      if (r_state == WAIT) begin
        if (mm_rsp_valid) begin
          r_data <= mm_rsp_data;
          r_berr <= mm_rsp_bus_error;
        end else if (r_cnt == TO_LAST) begin
          r_data <= '0;
          r_berr <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      if (mm_rsp_valid && r_state != WAIT)
        r_stray <= 1'b1;
    end
  end

  assign ic_req_grant = w_gnt_ic;
  assign dc_req_grant = w_gnt_dc;

  assign mm_req_valid = (r_state == ISSUE);
  assign mm_req_info  = mm_req_valid ? r_info : '0;

  assign w_resp = (r_state == RESP);

  assign ic_rsp_valid     = w_resp && (r_src == SRC_IC);
  assign ic_rsp_data      = ic_rsp_valid ? r_data : '0;
  assign ic_rsp_thread_id = ic_rsp_valid ? r_thr : '0;
  assign ic_rsp_bus_error = ic_rsp_valid & r_berr;

  assign dc_rsp_valid     = w_resp && (r_src == SRC_DC);
  assign dc_rsp_data      = dc_rsp_valid ? r_data : '0;
  assign dc_rsp_thread_id = dc_rsp_valid ? r_thr : '0;
  assign dc_rsp_bus_error = dc_rsp_valid & r_berr;

  assign stray_rsp = r_stray;

endmodule
